// File: rtl/load_store_unit.sv
// load_store_unit: memory stage of the RV32I core.
// Accepts one operation at a time from execute, runs a single-outstanding
// request/grant/response transaction on the data-memory port, and produces
// an aligned, extended, registered writeback value. Stalls while busy.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/W accesses trap
// instead of being silently forced to natural alignment).
module load_store_unit #(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 mem_load,
    input  logic                 mem_store,
    input  logic [2:0]           mem_funct3,
    input  logic [DataWidth-1:0] eff_address,
    input  logic [DataWidth-1:0] store_data,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [3:0]           dmem_mask,
    output logic [DataWidth-1:0] dmem_addr,
    output logic [DataWidth-1:0] dmem_wdata,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvalid,
    input  logic [DataWidth-1:0] dmem_rdata,
    output logic                 done,
    output logic                 wb_valid,
    output logic [DataWidth-1:0] wb_data,
    output logic                 stall,
    output logic                 misaligned
);

    localparam int NumLanes = DataWidth / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state_q;
    logic                 req_ready_q;
    logic                 stall_q;
    logic                 dmem_req_q;
    logic                 dmem_we_q;
    logic [3:0]           dmem_mask_q;
    logic [DataWidth-1:0] dmem_addr_q;
    logic [DataWidth-1:0] dmem_wdata_q;
    logic                 done_q;
    logic                 wb_valid_q;
    logic [DataWidth-1:0] wb_data_q;
    logic                 misaligned_q;
    logic [2:0]           funct3_q;
    logic [1:0]           offset_q;
    logic                 is_store_q;

    // Decode of the operation presented in IDLE
    logic [1:0]           size_d;
    logic [1:0]           offset_d;
    logic                 illegal_d;
    logic                 trap_d;
    logic [3:0]           mask_d;
    logic [DataWidth-1:0] wdata_d;

    // Load-path extraction
    logic [7:0]           rd_byte [NumLanes];
    logic [15:0]          rd_half;
    logic [DataWidth-1:0] load_value;

    // Split the read word into byte lanes so the selected lane is a plain index
    generate
        for (genvar gi = 0; gi < NumLanes; gi++) begin : g_lane
            assign rd_byte[gi] = dmem_rdata[8*gi +: 8];
        end
    endgenerate

    // Decode size, illegal funct3, alignment handling and store lane placement
    always_comb begin
        size_d    = mem_funct3[1:0];
        illegal_d = (mem_funct3 == 3'b011) || (mem_funct3 == 3'b110) ||
                    (mem_funct3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
        offset_d  = eff_address[1:0];
        trap_d    = ((size_d == 2'b01) && eff_address[0]) ||
                    ((size_d == 2'b10) && (eff_address[1:0] != 2'b00));
`else
        // Force natural alignment: halves keep addr[1], words drop both bits
        offset_d  = eff_address[1:0];
        trap_d    = 1'b0;
        if (size_d == 2'b01) begin
            offset_d[0] = 1'b0;
        end else if (size_d == 2'b10) begin
            offset_d = 2'b00;
        end
`endif
        mask_d  = 4'b1111;
        wdata_d = store_data;
        case (size_d)
            2'b00: begin
                mask_d  = 4'b0001 << offset_d;
                wdata_d = {4{store_data[7:0]}};
            end
            2'b01: begin
                mask_d  = offset_d[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{store_data[15:0]}};
            end
            default: begin
                mask_d  = 4'b1111;
                wdata_d = store_data;
            end
        endcase
    end

    // Select and extend the returned lane according to the captured funct3
    always_comb begin
        rd_half = offset_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_value = {{24{rd_byte[offset_q][7]}}, rd_byte[offset_q]};
            3'b100:  load_value = {24'd0, rd_byte[offset_q]};
            3'b001:  load_value = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_value = {16'd0, rd_half};
            default: load_value = dmem_rdata;
        endcase
    end

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            stall_q      <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_mask_q  <= 4'b0000;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            done_q       <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            misaligned_q <= 1'b0;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            is_store_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        stall_q     <= 1'b1;
                        funct3_q    <= mem_funct3;
                        offset_q    <= offset_d;
                        is_store_q  <= mem_store;
                        if (!(mem_load || mem_store)) begin
                            // ALU pass-through
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            wb_valid_q <= 1'b1;
                            wb_data_q  <= eff_address;
                        end else if (illegal_d) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            wb_data_q <= '0;
                        end else if (trap_d) begin
                            state_q      <= DONE;
                            done_q       <= 1'b1;
                            misaligned_q <= 1'b1;
                        end else begin
                            state_q      <= REQ;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= mem_store;
                            dmem_mask_q  <= mask_d;
                            dmem_addr_q  <= {eff_address[DataWidth-1:2], 2'b00};
                            dmem_wdata_q <= wdata_d;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (is_store_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        wb_valid_q <= 1'b1;
                        wb_data_q  <= load_value;
                    end
                end
                DONE: begin
                    state_q      <= IDLE;
                    done_q       <= 1'b0;
                    wb_valid_q   <= 1'b0;
                    misaligned_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    stall_q      <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign stall      = stall_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_mask  = dmem_mask_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign done       = done_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign misaligned = misaligned_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit
// against a behavioural model of the memory-stage rules.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        mem_load;
    logic        mem_store;
    logic [2:0]  mem_funct3;
    logic [31:0] eff_address;
    logic [31:0] store_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_mask;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        done;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        stall;
    logic        misaligned;

    int total = 0;
    int bad   = 0;
    int op_no = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DataWidth(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .mem_load    (mem_load),
        .mem_store   (mem_store),
        .mem_funct3  (mem_funct3),
        .eff_address (eff_address),
        .store_data  (store_data),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_mask   (dmem_mask),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .done        (done),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .stall       (stall),
        .misaligned  (misaligned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Runs one operation starting at a negedge in IDLE; returns the wb_data
    // seen on the completion cycle. gd = grant wait cycles, rd = rvalid wait
    // cycles after the first WAIT cycle.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdat, input int gd, input int rd,
                          output logic [31:0] wb_seen);
        logic        is_mem, illegal, trap, access, exp_wbv;
        int          size, off, lat, sv;
        logic [31:0] exp_wb, exp_mask, exp_wdata, shifted;

        // Reference model
        is_mem  = ld | st;
        size    = int'(f3) % 4;
        illegal = is_mem && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        trap    = is_mem && !illegal &&
                  ((size == 1 && (addr % 2) != 0) || (size == 2 && (addr % 4) != 0));
`else
        trap    = 1'b0;
`endif
        access  = is_mem && !illegal && !trap;
        if (size == 0)      off = int'(addr % 4);
        else if (size == 1) off = int'((addr % 4) / 2) * 2;
        else                off = 0;
        if (!access)  lat = 1;
        else if (st)  lat = 2 + gd;
        else          lat = 3 + gd + rd;

        if (size == 0) begin
            exp_mask  = 32'(1 << off);
            exp_wdata = (data & 32'hFF) * 32'h0101_0101;
        end else if (size == 1) begin
            exp_mask  = 32'(3 << off);
            exp_wdata = (data & 32'hFFFF) * 32'h0001_0001;
        end else begin
            exp_mask  = 32'hF;
            exp_wdata = data;
        end

        shifted = rdat >> (8 * off);
        case (f3)
            3'd0: begin sv = int'(shifted & 32'hFF);   if (sv >= 128)   sv -= 256;   exp_wb = 32'(sv); end
            3'd4: exp_wb = shifted & 32'hFF;
            3'd1: begin sv = int'(shifted & 32'hFFFF); if (sv >= 32768) sv -= 65536; exp_wb = 32'(sv); end
            3'd5: exp_wb = shifted & 32'hFFFF;
            default: exp_wb = rdat;
        endcase
        if (!is_mem)      exp_wb = addr;
        else if (illegal) exp_wb = 32'd0;
        exp_wbv = !is_mem || (access && !st);

        // Present the operation (cycle T)
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid   = 1'b1;
        mem_load    = ld;
        mem_store   = st;
        mem_funct3  = f3;
        eff_address = addr;
        store_data  = data;
        @(negedge clk);
        req_valid   = 1'b0;
        eff_address = $urandom;
        store_data  = $urandom;
        wb_seen     = 32'd0;

        for (int c = 1; c <= lat; c++) begin
            check("done", {31'd0, done}, {31'd0, c == lat});
            check("stall", {31'd0, stall}, 32'd1);
            check("ready_busy", {31'd0, req_ready}, 32'd0);
            if (access && c <= 1 + gd) begin
                check("dmem_req", {31'd0, dmem_req}, 32'd1);
                check("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
                check("dmem_we", {31'd0, dmem_we}, {31'd0, st});
                if (st) begin
                    check("dmem_mask", {28'd0, dmem_mask}, exp_mask);
                    check("dmem_wdata", dmem_wdata, exp_wdata);
                end
            end else begin
                check("dmem_req_idle", {31'd0, dmem_req}, 32'd0);
            end
            if (c == lat) begin
                wb_seen = wb_data;
                if (!illegal)
                    check("wb_valid", {31'd0, wb_valid}, {31'd0, exp_wbv});
                if (exp_wbv || illegal)
                    check("wb_data", wb_data, exp_wb);
                check("misaligned", {31'd0, misaligned}, {31'd0, trap});
            end
            // Memory-side drive for this cycle
            dmem_gnt    = access && (c == 1 + gd);
            dmem_rvalid = access && !st && (c == 2 + gd + rd);
            dmem_rdata  = dmem_rvalid ? rdat : $urandom;
            if (access && c <= gd && ($urandom % 2 == 1)) dmem_rvalid = 1'b1;
            if (c == lat && ($urandom % 2 == 1))          dmem_rvalid = 1'b1;
            @(negedge clk);
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        check("done_clear", {31'd0, done}, 32'd0);
        check("wbv_clear", {31'd0, wb_valid}, 32'd0);
        check("stall_clear", {31'd0, stall}, 32'd0);
        check("misaligned_clear", {31'd0, misaligned}, 32'd0);
        op_no++;
        $display("op %0d ld=%0d st=%0d f3=%0d addr=%h data=%h rdata=%h lat=%0d wb=%h",
                 op_no, ld, st, f3, addr, data, rdat, lat, wb_seen);
    endtask

    initial begin
        logic [31:0] wb;
        logic [2:0]  ld_f3  [5];
        logic [2:0]  ill_f3 [3];
        int          k;
        ld_f3  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        ill_f3 = '{3'd3, 3'd6, 3'd7};

        rst = 1'b1; req_valid = 1'b0; mem_load = 1'b0; mem_store = 1'b0;
        mem_funct3 = 3'd0; eff_address = 32'd0; store_data = 32'd0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_mask", {28'd0, dmem_mask}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(1'b0, 1'b1, 3'd2, 32'h0000_1004, 32'hDEAD_BEEF, 32'd0, 0, 0, wb);
        run_op(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'd0, 1, 0, wb);
        run_op(1'b1, 1'b0, 3'd0, 32'h0000_2001, 32'h0, 32'h0000_8000, 2, 0, wb);
        check("tp_lb", wb, 32'hFFFF_FF80);
        run_op(1'b1, 1'b0, 3'd4, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 1, wb);
        check("tp_lbu", wb, 32'h0000_0080);
        run_op(1'b1, 1'b0, 3'd5, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 0, wb);
        check("tp_lhu", wb, 32'h0000_BEEF);
        run_op(1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 0, 0, wb);
        check("tp_pass", wb, 32'h1234_5678);
        run_op(1'b1, 1'b0, 3'd2, 32'h0000_3002, 32'h0, 32'hCAFE_F00D, 0, 0, wb);
        run_op(1'b1, 1'b0, 3'd3, 32'h0000_4000, 32'h0, 32'h0, 0, 0, wb);

        // Reset in WAIT, then a late rvalid must be ignored
        req_valid = 1'b1; mem_load = 1'b1; mem_store = 1'b0; mem_funct3 = 3'd2;
        eff_address = 32'h0000_5000;
        @(negedge clk);
        req_valid = 1'b0; dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_wb_data", wb_data, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_wbv", {31'd0, wb_valid}, 32'd0);
        check("midrst_dmem_req", {31'd0, dmem_req}, 32'd0);
        run_op(1'b1, 1'b0, 3'd1, 32'h0000_6002, 32'h0, 32'h8001_7FFF, 1, 1, wb);
        check("post_rst_lh", wb, 32'hFFFF_8001);

        // Randomized mix
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            if (k <= 3)
                run_op(k == 3, 1'b1, 3'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
                       $urandom_range(0, 3), 0, wb);
            else if (k <= 7)
                run_op(1'b1, 1'b0, ld_f3[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3), wb);
            else if (k == 8)
                run_op(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 0, 0, wb);
            else
                run_op(1'b1, 1'b0, ill_f3[$urandom_range(0, 2)], $urandom, $urandom, $urandom, 0, 0, wb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage block of the RV32I core that sits directly downstream of the execute stage: it consumes the ALU result as an effective address (or as a pass-through value) together with store data, and runs a single-outstanding request/grant/response transaction on the data-memory port. Load data is aligned and sign/zero-extended into a registered writeback value. While a transaction is in flight, the block stalls the pipeline.

## Interface
Parameters:
- DataWidth, 32, datapath width; only 32 is supported (4 byte lanes).

Ports (reset is asynchronous and active-high on `rst`):
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  execute stage presents an operation
- req_ready  out  1  block can accept; high only in IDLE
- mem_load  in  1  operation is a load
- mem_store  in  1  operation is a store; wins if both are set
- mem_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- eff_address  in  DataWidth  ALU result / effective address
- store_data  in  DataWidth  rs2 value
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_mask  out  4  byte-lane enables
- dmem_addr  out  DataWidth  word address, bits [1:0] = 0
- dmem_wdata  out  DataWidth  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  DataWidth  read word
- done  out  1  one-cycle completion pulse
- wb_valid  out  1  one-cycle pulse; wb_data is valid
- wb_data  out  DataWidth  registered writeback value
- stall  out  1  high whenever state != IDLE
- misaligned  out  1  one-cycle trap pulse (see Configuration)

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: an operation is accepted when req_valid and req_ready are both high. Address, data, funct3 and op type are captured.
  - Store or load → REQ.
  - Neither flag set → DONE with wb_data = eff_address (ALU pass-through) and wb_valid asserted.
  - funct3 011/110/111 → DONE with no memory access and wb_data = 0.
- REQ: dmem_req=1 and all dmem_* outputs are stable until dmem_gnt.
  - Store + gnt → DONE.
  - Load + gnt → WAIT.
  - dmem_rvalid in REQ is ignored.
- WAIT: on dmem_rvalid, extract the lane selected by address bits [1:0], extend it, register it into wb_data, then → DONE.
- DONE: done=1 for one cycle (wb_valid=1 for loads and pass-through), then → IDLE.
- Store lanes:
  - SB: byte replicated ×4; mask = 1 << addr[1:0].
  - SH: half replicated ×2; mask = 0011 if addr[1]=0, 1100 if addr[1]=1.
  - SW: mask 1111.
- Load extend:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: word unchanged.
- dmem_rvalid in IDLE or DONE is ignored.

## Timing
- Reset values: all outputs 0 except req_ready=1; state is IDLE. Reset mid-transaction abandons it without asserting done.
- Accept in cycle T → dmem_req rises at T+1 (registered).
- Store with gnt at T+1 → done at T+2.
- Load with gnt at T+1 and rvalid at T+2 → done/wb_valid at T+3. Each wait cycle on gnt or rvalid adds one cycle.
- Pass-through, illegal funct3 and trapped ops → done at T+1.
- A new operation can be accepted in the cycle after DONE (req_ready high again). There is no back-to-back accept while busy.
- gnt and rvalid are allowed in the same cycle only on separate transactions. rvalid must arrive at least one cycle after gnt.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - H access with addr[0]=1, or W access with addr[1:0]≠0 → no dmem access.
  - DONE at T+1 with misaligned=1, done=1, wb_valid=0.
- Not defined:
  - Low address bits are forced to natural alignment: H uses addr[1] only; W ignores addr[1:0].
  - misaligned is tied to 0.

## Test plan
- SW addr 0x0000_1004, data 0xDEAD_BEEF, gnt immediate → dmem_addr 0x1004, mask 1111, we=1, done at T+2, wb_valid=0.
- SB addr 0x1003, data 0x0000_00A5 → mask 1000, wdata 0xA5A5_A5A5.
- LB addr 0x2001, rdata 0x0000_8000, gnt delayed 2 cycles, rvalid 1 cycle later → wb_data 0xFFFF_FF80, wb_valid at T+5. LBU at the same address → 0x0000_0080.
- LHU addr 0x2002, rdata 0xBEEF_1234 → wb_data 0x0000_BEEF. Pass-through eff_address 0x1234_5678 → wb_data 0x1234_5678 at T+1, no dmem_req.
- LW addr 0x3002:
  - With LSU_MISALIGN_TRAP_EN: misaligned pulse at T+1, no dmem_req.
  - Without it: dmem_addr 0x3000, normal load.
- rst asserted while in WAIT, then rvalid arrives → outputs return to reset values, no done/wb_valid pulse, and the next accepted op completes normally.
